// File: rtl/command_dispatch_ctrl_if.sv
// Command bus between the dispatcher and the execution engine. The dispatcher
// drives the command fields, and the engine returns the accept and completion signals.
interface command_dispatch_ctrl_if #(
    parameter int DATA_W   = 32,
    parameter int MAX_ARGS = 3
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [3:0]                   cmd_opcode;
    logic [1:0]                   cmd_nargs;
    logic [23:0]                  cmd_imm;
    logic [MAX_ARGS*DATA_W-1:0]   cmd_args;
    logic                         engine_done;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_nargs,
        output cmd_imm,
        output cmd_args,
        input  cmd_ready,
        input  engine_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_nargs,
        input  cmd_imm,
        input  cmd_args,
        output cmd_ready,
        output engine_done
    );
endinterface

// File: rtl/command_dispatch_ctrl.sv
// Drains header+argument commands from the command FIFO and hands them to the engine.
// Define CMD_DISPATCH_TIMEOUT_EN to add a done-timeout that ends in ERROR (err_code 10).
module command_dispatch_ctrl #(
    parameter int DATA_W    = 32,
    parameter int MAX_ARGS  = 3,
    parameter int TIMEOUT_W = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [DATA_W-1:0]       read_data,
    output logic                    fifo_read,
    command_dispatch_ctrl_if.master cmd,
    input  logic                    clear_error,
    output logic                    busy,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [15:0]             cmds_issued
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARGS      = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;

    state_t                     state;
    logic [1:0]                 arg_idx;
    logic [MAX_ARGS*DATA_W-1:0] arg_q;

    logic [3:0]  hdr_op;
    logic [1:0]  hdr_nargs;
    logic [23:0] hdr_imm;
    logic        arg_last;

    function automatic logic is_blocking(input logic [3:0] op);
        return (op >= 4'h8) && (op != OP_ILLEGAL);
    endfunction

    assign hdr_op    = read_data[31:28];
    assign hdr_nargs = read_data[25:24];
    assign hdr_imm   = read_data[23:0];
    assign arg_last  = (arg_idx == (cmd.cmd_nargs - 2'd1));
    assign cmd.cmd_args = arg_q;

`ifdef CMD_DISPATCH_TIMEOUT_EN
    localparam logic [1:0]           ERR_TIMEOUT = 2'b10;
    localparam logic [TIMEOUT_W-1:0] TO_ONE      = 1;
    localparam logic [TIMEOUT_W-1:0] TO_LAST     = '1;
    logic [TIMEOUT_W-1:0] to_cnt;
`else
    // The timeout width has no effect in this build; keep a legal value anyway.
    if (TIMEOUT_W < 1) begin : g_timeout_w_unused
    end
`endif

    // Pops are suppressed during reset, since the FIFO is resetting as well.
    always_comb begin
        fifo_read = 1'b0;
        if (n_rst && !fifo_empty) begin
            if (state == IDLE && enable) begin
                fifo_read = 1'b1;
            end else if (state == ARGS) begin
                fifo_read = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            error           <= 1'b0;
            err_code        <= 2'b00;
            cmds_issued     <= 16'd0;
            arg_idx         <= 2'd0;
            arg_q           <= '0;
            cmd.cmd_valid   <= 1'b0;
            cmd.cmd_opcode  <= 4'h0;
            cmd.cmd_nargs   <= 2'd0;
            cmd.cmd_imm     <= 24'd0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
            to_cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_read) begin
                        cmd.cmd_opcode <= hdr_op;
                        cmd.cmd_nargs  <= hdr_nargs;
                        cmd.cmd_imm    <= hdr_imm;
                        arg_q          <= '0;
                        arg_idx        <= 2'd0;
                        if (hdr_op == OP_ILLEGAL) begin
                            state    <= ERROR;
                            busy     <= 1'b1;
                            error    <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (hdr_nargs != 2'd0) begin
                            state <= ARGS;
                            busy  <= 1'b1;
                        end else if (hdr_op != OP_NOP) begin
                            state         <= ISSUE;
                            busy          <= 1'b1;
                            cmd.cmd_valid <= 1'b1;
                        end
                    end
                end

                ARGS: begin
                    if (fifo_read) begin
                        for (int k = 0; k < MAX_ARGS; k++) begin
                            if (int'(arg_idx) == k) begin
                                arg_q[k*DATA_W +: DATA_W] <= read_data;
                            end
                        end
                        arg_idx <= arg_idx + 2'd1;
                        if (arg_last) begin
                            if (cmd.cmd_opcode == OP_NOP) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state         <= ISSUE;
                                cmd.cmd_valid <= 1'b1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (cmd.cmd_ready) begin
                        cmd.cmd_valid <= 1'b0;
                        cmds_issued   <= cmds_issued + 16'd1;
                        if (is_blocking(cmd.cmd_opcode)) begin
                            state <= WAIT_DONE;
`ifdef CMD_DISPATCH_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (cmd.engine_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`ifdef CMD_DISPATCH_TIMEOUT_EN
                    else begin
                        to_cnt <= to_cnt + TO_ONE;
                        // The cycle whose increment lands on the terminal count gives up.
                        if (to_cnt == (TO_LAST - TO_ONE)) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                        end
                    end
`endif
                end

                ERROR: begin
                    if (clear_error) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        error <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    error         <= 1'b0;
                    cmd.cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
